// File: rtl/prog_mem_ctrl_if.sv
// rtl/prog_mem_ctrl_if.sv - fetch, host-loader and program-memory signal bundle
// master drives requests/host words/memory read data; slave is the controller.
interface prog_mem_ctrl_if #(
   parameter int DATA_SIZE = 6,
   parameter int ADDR_SIZE = 5
);
   logic                 fetch_req;
   logic [ADDR_SIZE-1:0] fetch_addr;
   logic [DATA_SIZE-1:0] fetch_data;
   logic                 fetch_valid;
   logic                 cpu_hold;
   logic                 load_start;
   logic [ADDR_SIZE:0]   load_len;
   logic                 host_valid;
   logic [DATA_SIZE-1:0] host_data;
   logic                 host_ready;
   logic                 load_done;
   logic [ADDR_SIZE-1:0] mem_addr;
   logic [DATA_SIZE-1:0] mem_wdata;
   logic                 mem_we;
   logic [DATA_SIZE-1:0] mem_rdata;

   modport master (
      output fetch_req, fetch_addr, load_start, load_len, host_valid, host_data, mem_rdata,
      input  fetch_data, fetch_valid, cpu_hold, host_ready, load_done, mem_addr, mem_wdata, mem_we
   );

   modport slave (
      input  fetch_req, fetch_addr, load_start, load_len, host_valid, host_data, mem_rdata,
      output fetch_data, fetch_valid, cpu_hold, host_ready, load_done, mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/prog_mem_ctrl.sv
// rtl/prog_mem_ctrl.sv - program-memory port arbiter between CPU fetch and host loader
// A load burst writes from address 0 upward and stalls the CPU until it completes.
module prog_mem_ctrl #(
   parameter int DATA_SIZE = 6,
   parameter int ADDR_SIZE = 5
) (
   input logic            clk,
   input logic            rstn,
   prog_mem_ctrl_if.slave bus
);
   localparam int                 DEPTH     = 2 ** ADDR_SIZE;
   localparam logic [ADDR_SIZE:0] DEPTH_LEN = (ADDR_SIZE + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_SIZE:0]   remaining_q, remaining_d;
   logic [ADDR_SIZE:0]   len_clamped;
   logic [DATA_SIZE-1:0] fetch_data_q, fetch_data_d;
   logic                 fetch_valid_q, fetch_valid_d;
   logic                 cpu_hold_q, cpu_hold_d;
   logic                 load_done_q, load_done_d;
   logic                 xfer;

   assign xfer = (state_q == S_LOAD) && bus.host_valid;

   always_comb begin
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      remaining_d   = remaining_q;
      fetch_data_d  = fetch_data_q;
      fetch_valid_d = 1'b0;
      len_clamped   = (bus.load_len > DEPTH_LEN) ? DEPTH_LEN : bus.load_len;

      case (state_q)
         S_IDLE: begin
            // Fetch and load start may share an edge: the fetch still completes.
            if (bus.fetch_req) begin
               fetch_data_d  = bus.mem_rdata;
               fetch_valid_d = 1'b1;
            end
            if (bus.load_start) begin
               if (len_clamped == '0) begin
                  state_d = S_DONE;
               end else begin
                  wr_ptr_d    = '0;
                  remaining_d = len_clamped;
                  state_d     = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            if (xfer) begin
               wr_ptr_d    = wr_ptr_q + 1'b1;
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == (ADDR_SIZE + 1)'(1)) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      cpu_hold_d  = (state_d != S_IDLE);
      load_done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= S_IDLE;
         wr_ptr_q      <= '0;
         remaining_q   <= '0;
         fetch_data_q  <= '0;
         fetch_valid_q <= 1'b0;
         cpu_hold_q    <= 1'b0;
         load_done_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         remaining_q   <= remaining_d;
         fetch_data_q  <= fetch_data_d;
         fetch_valid_q <= fetch_valid_d;
         cpu_hold_q    <= cpu_hold_d;
         load_done_q   <= load_done_d;
      end
   end

   assign bus.fetch_data  = fetch_data_q;
   assign bus.fetch_valid = fetch_valid_q;
   assign bus.cpu_hold    = cpu_hold_q;
   assign bus.load_done   = load_done_q;
   assign bus.host_ready  = (state_q == S_LOAD);
   assign bus.mem_addr    = (state_q == S_LOAD) ? wr_ptr_q : bus.fetch_addr;
   assign bus.mem_wdata   = (state_q == S_LOAD) ? bus.host_data : '0;
   assign bus.mem_we      = xfer;
endmodule

// File: tb/tb_prog_mem_ctrl.sv
// tb/tb_prog_mem_ctrl.sv - self-checking bench for prog_mem_ctrl
// Transaction-level model: expected memory image, expected write list, hold/done counts.
module tb_prog_mem_ctrl;
   localparam int DW    = 6;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   prog_mem_ctrl_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) bus ();
   prog_mem_ctrl #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] ref_mem [DEPTH];
   always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
   assign bus.mem_rdata = mem[bus.mem_addr];

   wr_t wr_q[$];
   int  hold_cnt = 0;
   int  done_cnt = 0;
   always @(posedge clk) begin
      if (bus.mem_we) wr_q.push_back({bus.mem_addr, bus.mem_wdata});
      if (bus.cpu_hold) hold_cnt++;
      if (bus.load_done) done_cnt++;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One burst. mode: 0 continuous, 1 alternating valid, 2 random gaps.
   // abort_after >= 0 pulls reset once that many words have been written.
   task automatic do_load(input int len, input int mode, input bit seq, input bit collide,
                          input int abort_after);
      int n, feed, idx, wr0, h0, d0, fa;
      bit valid;
      logic [DW-1:0] words[$];
      logic [DW-1:0] old;
      n = (len > DEPTH) ? DEPTH : len;
      for (int k = 0; k < n; k++) words.push_back(seq ? DW'(k) : DW'($urandom));
      wr0 = wr_q.size(); h0 = hold_cnt; d0 = done_cnt;
      fa  = $urandom_range(0, DEPTH - 1);
      old = ref_mem[fa];
      bus.load_start = 1'b1;
      bus.load_len   = (AW + 1)'(len);
      if (collide) begin
         bus.fetch_req  = 1'b1;
         bus.fetch_addr = AW'(fa);
      end
      @(negedge clk);
      bus.load_start = 1'b0;
      bus.load_len   = (AW + 1)'($urandom);
      chk("hold_after_start", bus.cpu_hold, 1);
      if (collide) begin
         chk("collide_valid", bus.fetch_valid, 1);
         chk("collide_data", bus.fetch_data, old);
      end
      idx = 0; feed = 0;
      while (idx < n && feed < 400) begin
         if (abort_after >= 0 && idx == abort_after) break;
         valid = (mode == 0) || (mode == 1 && feed % 2 == 0) ||
                 (mode == 2 && $urandom_range(0, 99) >= 40);
         chk("host_ready", bus.host_ready, 1);
         if (collide && feed > 0) chk("fetch_dropped", bus.fetch_valid, 0);
         bus.host_valid = valid;
         bus.host_data  = valid ? words[idx] : DW'($urandom);
         @(negedge clk);
         if (valid) begin
            ref_mem[idx] = words[idx];
            idx++;
         end
         feed++;
      end
      if (feed >= 400) chk("feed_timeout", feed, 0);
      bus.fetch_req = 1'b0;

      if (abort_after >= 0) begin
         bus.host_valid = 1'b1;
         rstn = 1'b0;
         #1;
         chk("abort_hold", bus.cpu_hold, 0);
         chk("abort_ready", bus.host_ready, 0);
         chk("abort_done", bus.load_done, 0);
         chk("abort_we", bus.mem_we, 0);
         bus.host_valid = 1'b0;
         @(negedge clk);
         rstn = 1'b1;
         chk("abort_no_done_pulse", done_cnt - d0, 0);
         chk("abort_writes", wr_q.size() - wr0, abort_after);
         return;
      end

      bus.host_valid = 1'b0;
      chk("done_pulse", bus.load_done, 1);
      if (collide) chk("fetch_dropped_done", bus.fetch_valid, 0);
      @(negedge clk);
      chk("hold_released", bus.cpu_hold, 0);
      chk("done_cleared", bus.load_done, 0);
      chk("hold_cycles", hold_cnt - h0, feed + 1);
      chk("done_count", done_cnt - d0, 1);
      chk("write_count", wr_q.size() - wr0, n);
      if (wr_q.size() - wr0 == n) begin
         for (int k = 0; k < n; k++) begin
            chk("wr_addr", wr_q[wr0 + k].a, k);
            chk("wr_data", wr_q[wr0 + k].d, words[k]);
         end
      end
   endtask

   task automatic fetch_burst(input int cnt, input int fixed_addr);
      int a;
      a = 0;
      for (int i = 0; i < cnt; i++) begin
         a = (fixed_addr >= 0) ? fixed_addr : $urandom_range(0, DEPTH - 1);
         bus.fetch_req  = 1'b1;
         bus.fetch_addr = AW'(a);
         @(negedge clk);
         chk("fetch_valid", bus.fetch_valid, 1);
         chk("fetch_data", bus.fetch_data, ref_mem[a]);
      end
      bus.fetch_req  = 1'b0;
      bus.fetch_addr = AW'($urandom);
      @(negedge clk);
      chk("fetch_idle_valid", bus.fetch_valid, 0);
      chk("fetch_data_hold", bus.fetch_data, ref_mem[a]);
   endtask

   initial begin
      rstn           = 1'b0;
      bus.fetch_req  = 1'b0;
      bus.fetch_addr = AW'(7);
      bus.load_start = 1'b0;
      bus.load_len   = '0;
      bus.host_valid = 1'b0;
      bus.host_data  = '0;
      repeat (2) @(negedge clk);
      chk("rst_fetch_valid", bus.fetch_valid, 0);
      chk("rst_fetch_data", bus.fetch_data, 0);
      chk("rst_hold", bus.cpu_hold, 0);
      chk("rst_done", bus.load_done, 0);
      chk("rst_ready", bus.host_ready, 0);
      chk("rst_we", bus.mem_we, 0);
      chk("rst_addr", bus.mem_addr, 7);
      chk("rst_wdata", bus.mem_wdata, 0);
      rstn = 1'b1;
      @(negedge clk);

      do_load(32, 0, 1'b1, 1'b0, -1);
      fetch_burst(1, 5);
      chk("addr5_word", bus.fetch_data, 5);
      fetch_burst(8, -1);

      do_load(3, 1, 1'b0, 1'b0, -1);
      fetch_burst(4, -1);

      do_load(40, 2, 1'b0, 1'b0, -1);
      do_load(0, 0, 1'b0, 1'b0, -1);
      fetch_burst(3, -1);

      do_load(4, 0, 1'b0, 1'b1, -1);
      fetch_burst(3, -1);

      do_load(10, 0, 1'b0, 1'b0, 4);
      do_load(5, 2, 1'b0, 1'b0, -1);
      fetch_burst(6, -1);

      repeat (4) begin
         do_load($urandom_range(0, 40), $urandom_range(0, 2), 1'b0, 1'($urandom_range(0, 1)), -1);
         fetch_burst($urandom_range(1, 6), -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
